interrupt_controller: RTL and testbench

Six-source programmable interrupt controller between peripheral devices (timers, UART, GPIO) and the CP0 interrupt inputs. It synchronises raw device lines, latches edge- or level-triggered requests, applies per-source enables and fixed nested priority, and drives a registered `HWInterruptRequest[7:2]` into CP0. The CPU configures, acknowledges and ends service of interrupts through a 4-word memory-mapped register window on the bus bridge.

---
 rtl/interrupt_controller_if.sv | 11 +
 rtl/interrupt_controller.sv | 116 +++++++++++
 tb/tb_interrupt_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// CPU-side register window of the interrupt controller: 2-bit select, write strobe,
// write data and combinational read data.
interface interrupt_controller_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (output Addr, output WE, output DataIn, input DataOut);
  modport slave  (input Addr, input WE, input DataIn, output DataOut);
endinterface

// File: rtl/interrupt_controller.sv
// Six-source interrupt controller: synchronises device lines, latches edge/level requests,
// and presents the single highest-priority eligible source to CP0 HWInterruptRequest[7:2].
module interrupt_controller #(
  parameter int unsigned SRC_COUNT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SRC_COUNT-1:0]   DevIrq,
  interrupt_controller_if.slave  bus,
  output logic [SRC_COUNT+1:2]   HWInterruptRequest
);

  logic [SRC_COUNT-1:0] s1Q, s2Q, prevQ;
  logic [SRC_COUNT-1:0] enQ, enD, modeQ, modeD;
  logic                 genQ, genD;
  logic [SRC_COUNT-1:0] pendQ, pendD, isrQ, isrD, hwQ, hwD;

  logic                 ctrlWr, pendWr, vecWr, eoiWr;
  logic [2:0]           id;
  logic [SRC_COUNT-1:0] newEdge, modeChg, ackHit, eoiHit, w1c, edgePend, elig;
  logic                 anyElig, blocked;
  logic [2:0]           vecIdx;
  logic [31:0]          vecRd;
  logic                 unusedDataIn;

  assign unusedDataIn = ^{bus.DataIn[31:17], bus.DataIn[15:14], bus.DataIn[7:6]};

  always_comb begin
    ctrlWr  = bus.WE && (bus.Addr == 2'd0);
    pendWr  = bus.WE && (bus.Addr == 2'd1);
    vecWr   = bus.WE && (bus.Addr == 2'd2);
    eoiWr   = bus.WE && (bus.Addr == 2'd3);
    id      = bus.DataIn[2:0];
    newEdge = s2Q & ~prevQ;
    modeChg = ctrlWr ? (bus.DataIn[8 +: SRC_COUNT] ^ modeQ) : '0;
    w1c     = pendWr ? bus.DataIn[SRC_COUNT-1:0] : '0;
    ackHit  = '0;
    eoiHit  = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      ackHit[i] = vecWr && (id == 3'(i)) && pendQ[i];
      eoiHit[i] = eoiWr && (id == 3'(i));
    end

    // A new edge outranks W1C and acknowledge; an acknowledge outranks EOI.
    edgePend = (pendQ & ~(w1c | ackHit)) | newEdge;
    pendD    = ((modeQ & edgePend) | (~modeQ & s2Q)) & ~modeChg;
    isrD     = ((isrQ & ~eoiHit) | ackHit) & ~modeChg;

    enD   = ctrlWr ? bus.DataIn[SRC_COUNT-1:0] : enQ;
    modeD = ctrlWr ? bus.DataIn[8 +: SRC_COUNT] : modeQ;
    genD  = ctrlWr ? bus.DataIn[16] : genQ;
  end

  // Any in-service bit at or above a source's priority blocks it.
  always_comb begin
    blocked = 1'b0;
    elig    = '0;
    hwD     = '0;
    vecIdx  = 3'd0;
    anyElig = 1'b0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      blocked = blocked | isrQ[i];
      elig[i] = pendQ[i] & enQ[i] & genQ & ~blocked;
      if (elig[i] && !anyElig) begin
        hwD[i]  = 1'b1;
        vecIdx  = 3'(i);
        anyElig = 1'b1;
      end
    end
  end

  always_comb begin
    vecRd                   = '0;
    vecRd[31]               = anyElig;
    vecRd[8 +: SRC_COUNT]   = isrQ;
    vecRd[2:0]              = vecIdx;
    bus.DataOut             = '0;
    unique case (bus.Addr)
      2'd0: begin
        bus.DataOut[SRC_COUNT-1:0]  = enQ;
        bus.DataOut[8 +: SRC_COUNT] = modeQ;
        bus.DataOut[16]             = genQ;
      end
      2'd1:    bus.DataOut[SRC_COUNT-1:0] = pendQ;
      2'd2:    bus.DataOut = vecRd;
      default: bus.DataOut = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Q   <= '0;
      s2Q   <= '0;
      prevQ <= '0;
      enQ   <= '0;
      modeQ <= '0;
      genQ  <= 1'b0;
      pendQ <= '0;
      isrQ  <= '0;
      hwQ   <= '0;
    end else begin
      s1Q   <= DevIrq;
      s2Q   <= s1Q;
      prevQ <= s2Q;
      enQ   <= enD;
      modeQ <= modeD;
      genQ  <= genD;
      pendQ <= pendD;
      isrQ  <= isrD;
      hwQ   <= hwD;
    end
  end

  assign HWInterruptRequest = hwQ;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: vector table for register sequences plus
// hand-written latency, conflict and reset cases.
module tb_interrupt_controller;

  logic       clk;
  logic       reset;
  logic [5:0] DevIrq;
  logic [7:2] HWInterruptRequest;
  int         total;
  int         bad;
  logic [31:0] rdData;

  interrupt_controller_if bus ();

  interrupt_controller #(.SRC_COUNT(6)) dut (
    .clk                (clk),
    .reset              (reset),
    .DevIrq             (DevIrq),
    .bus                (bus),
    .HWInterruptRequest (HWInterruptRequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [5:0]  dev;
    int          waits;
    logic [1:0]  rdAddr;
    logic [31:0] expRd;
    logic [5:0]  expHw;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr   = a;
    bus.DataIn = d;
    bus.WE     = 1'b1;
    tick();
    bus.WE     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DataOut;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // Level sources 1/3, then edge nesting of sources 4 and 2.
    vecs[0]  = '{1'b1, 2'd0, 32'h0001_000A, 6'h0A, 3, 2'd1, 32'h0000_000A, 6'h02};
    vecs[1]  = '{1'b1, 2'd2, 32'h0000_0001, 6'h0A, 1, 2'd2, 32'h0000_0200, 6'h00};
    vecs[2]  = '{1'b0, 2'd0, 32'h0000_0000, 6'h0A, 2, 2'd1, 32'h0000_000A, 6'h00};
    vecs[3]  = '{1'b1, 2'd3, 32'h0000_0001, 6'h0A, 1, 2'd2, 32'h8000_0001, 6'h02};
    vecs[4]  = '{1'b1, 2'd0, 32'h0001_1414, 6'h00, 3, 2'd0, 32'h0001_1414, 6'h00};
    vecs[5]  = '{1'b0, 2'd0, 32'h0000_0000, 6'h10, 4, 2'd2, 32'h8000_0004, 6'h10};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_0004, 6'h10, 1, 2'd2, 32'h0000_1000, 6'h00};
    vecs[7]  = '{1'b0, 2'd0, 32'h0000_0000, 6'h14, 4, 2'd2, 32'h8000_1002, 6'h04};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0002, 6'h14, 1, 2'd2, 32'h0000_1400, 6'h00};
    vecs[9]  = '{1'b1, 2'd3, 32'h0000_0002, 6'h14, 1, 2'd2, 32'h0000_1000, 6'h00};
    vecs[10] = '{1'b1, 2'd3, 32'h0000_0004, 6'h00, 1, 2'd2, 32'h0000_0000, 6'h00};

    reset      = 1'b0;
    DevIrq     = '0;
    bus.Addr   = 2'd0;
    bus.WE     = 1'b0;
    bus.DataIn = '0;
    #1;
    chk("rst_hw", 32'(HWInterruptRequest), 32'h0);
    chk("rst_ctrl", bus.DataOut, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    rd(2'd1, rdData); chk("rst_pend", rdData, 32'h0);
    rd(2'd2, rdData); chk("rst_vec", rdData, 32'h0);

    // Source 0 edge, 3-cycle pulse: output on the fourth edge after the rise.
    wr(2'd0, 32'h0001_0101);
    DevIrq = 6'h01;
    tick();
    chk("lat_e1", 32'(HWInterruptRequest), 32'h0);
    tick();
    tick();
    chk("lat_e3", 32'(HWInterruptRequest), 32'h0);
    DevIrq = 6'h00;
    tick();
    chk("lat_e4", 32'(HWInterruptRequest), 32'h01);
    rd(2'd2, rdData); chk("vec_src0", rdData, 32'h8000_0000);

    // Acknowledge and end of service for source 0.
    wr(2'd2, 32'h0);
    chk("ack_hw_lag", 32'(HWInterruptRequest), 32'h01);
    rd(2'd1, rdData); chk("ack_pend", rdData, 32'h0);
    rd(2'd2, rdData); chk("ack_isr", rdData, 32'h0000_0100);
    tick();
    chk("ack_hw", 32'(HWInterruptRequest), 32'h0);
    wr(2'd3, 32'h0);
    rd(2'd2, rdData); chk("eoi_vec", rdData, 32'h0);

    for (int i = 0; i < 11; i++) begin
      DevIrq = vecs[i].dev;
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      repeat (vecs[i].waits) tick();
      rd(vecs[i].rdAddr, rdData);
      chk($sformatf("vec%0d_rd", i), rdData, vecs[i].expRd);
      chk($sformatf("vec%0d_hw", i), 32'(HWInterruptRequest), 32'(vecs[i].expHw));
    end

    // New edge on source 5 lands in the same cycle as a W1C of it.
    wr(2'd0, 32'h0001_2020);
    tick();
    tick();
    DevIrq = 6'h20;
    tick();
    tick();
    wr(2'd1, 32'h0000_0020);
    rd(2'd1, rdData); chk("edge_vs_w1c", rdData, 32'h0000_0020);
    tick();
    chk("src5_hw", 32'(HWInterruptRequest), 32'h20);
    wr(2'd2, 32'h0000_0006);
    rd(2'd2, rdData); chk("ack_id6", rdData, 32'h8000_0005);
    wr(2'd1, 32'h0000_0020);
    rd(2'd1, rdData); chk("w1c_clear", rdData, 32'h0);
    DevIrq = 6'h00;

    // Asynchronous reset while source 0 is being requested.
    wr(2'd0, 32'h0001_0101);
    DevIrq = 6'h01;
    repeat (4) tick();
    chk("pre_rst_hw", 32'(HWInterruptRequest), 32'h01);
    DevIrq = 6'h00;
    reset  = 1'b0;
    #2;
    chk("async_rst_hw", 32'(HWInterruptRequest), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    rd(2'd0, rdData); chk("post_rst_ctrl", rdData, 32'h0);
    repeat (3) tick();
    rd(2'd1, rdData); chk("post_rst_pend", rdData, 32'h0);
    chk("post_rst_hw", 32'(HWInterruptRequest), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
